// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : eq_pkg
// Description : Shared types and default sizing for the equalizer sample queues.
// Revision    : 1.0 - initial release
// ============================================================================
package eq_pkg;

    localparam int c_SMPL_W = 16;

    // Low band uses a deeper history; both bands replay a full FIR tap set.
    localparam int c_LB_DEPTH    = 1536;
    localparam int c_LB_READ_LEN = 1021;
    localparam int c_HB_DEPTH    = 1024;
    localparam int c_HB_READ_LEN = 1021;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } q_state_t;

endpackage
`default_nettype wire

// File: rtl/dp_ram_queue.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_queue
// Description : Simple dual-port RAM, one write port and one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_queue #(
    parameter int DEPTH  = 1536,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read data register holds its value whenever no read is issued.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_queue.sv
`default_nettype none
// ============================================================================
// Module      : sample_queue
// Description : Dual-channel circular sample buffer; replays the newest READ_LEN
//               pairs oldest-first on seq/lft_out/rght_out after every write.
//               SAMPLE_QUEUE_OVERRUN_EN adds a sticky 'overrun' output.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_queue
    import eq_pkg::*;
#(
    parameter int DEPTH    = c_LB_DEPTH,
    parameter int READ_LEN = c_LB_READ_LEN,
    parameter int SMPL_W   = c_SMPL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_smpl,
    input  logic [SMPL_W-1:0] lft_smpl,
    input  logic [SMPL_W-1:0] rght_smpl,
    output logic              seq,
    output logic [SMPL_W-1:0] lft_out,
    output logic [SMPL_W-1:0] rght_out
`ifdef SAMPLE_QUEUE_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(READ_LEN + 1);

    generate
        if (DEPTH <= READ_LEN || READ_LEN < 2) begin : g_bad_params
            $fatal(1, "sample_queue: DEPTH must exceed READ_LEN and READ_LEN must be >= 2");
        end
    endgenerate

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    q_state_t              r_state;
    q_state_t              w_state_nxt;
    logic [c_PTR_W-1:0]    r_new_ptr;
    logic [c_PTR_W-1:0]    r_old_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    w_old_ptr_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    r_rd_cnt;
    logic                  r_seq;
    logic                  r_have_data;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_start;
    logic                  w_rd_en;
    logic                  w_last_rd;
    logic [2*SMPL_W-1:0]   w_rd_data;

    // A write is taken only once the previous burst has fully left the output.
    assign w_accept      = wrt_smpl && (r_state == IDLE) && !r_seq;
    assign w_full        = (r_cnt == c_CNT_W'(READ_LEN));
    assign w_start       = w_accept && (w_full || (r_cnt == c_CNT_W'(READ_LEN - 1)));
    assign w_old_ptr_nxt = (w_accept && w_full) ? ptr_inc(r_old_ptr) : r_old_ptr;
    assign w_last_rd     = (r_rd_cnt == c_CNT_W'(READ_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_rd_en = 1'b1;
                if (w_last_rd) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_ptr   <= '0;
            r_old_ptr   <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_rd_cnt    <= '0;
            r_seq       <= 1'b0;
            r_have_data <= 1'b0;
        end else begin
            if (w_accept) begin
                r_new_ptr <= ptr_inc(r_new_ptr);
                r_old_ptr <= w_old_ptr_nxt;
                if (!w_full) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_start) begin
                r_rd_ptr <= w_old_ptr_nxt;
                r_rd_cnt <= '0;
            end else if (w_rd_en) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            r_seq <= w_rd_en;
            if (w_rd_en) begin
                r_have_data <= 1'b1;
            end
        end
    end

    dp_ram_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * SMPL_W),
        .ADDR_W (c_PTR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_new_ptr),
        .i_wr_data ({lft_smpl, rght_smpl}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // The RAM output register has no reset, so it is masked until first read.
    assign seq      = r_seq;
    assign lft_out  = r_have_data ? w_rd_data[2*SMPL_W-1:SMPL_W] : '0;
    assign rght_out = r_have_data ? w_rd_data[SMPL_W-1:0]        : '0;

`ifdef SAMPLE_QUEUE_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (wrt_smpl && !w_accept) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

endmodule
`default_nettype wire

// File: doc/sample_queue.md
Name: sample_queue

Overview:
- Dual-channel circular sample buffer that feeds the band FIR filters.
- Stores each incoming left/right audio sample pair.
- Once READ_LEN samples are held, every new write triggers a replay burst: the most recent READ_LEN pairs are read out oldest-first, with `seq` high for exactly READ_LEN consecutive cycles.
- It is the producer end of the FIR `seq`/`lft_in`/`rght_in` interface.

Parameters:
- DEPTH, 1536, number of stored sample pairs; must exceed READ_LEN.
- READ_LEN, 1021, samples per replay burst; equals the FIR tap count.
- SMPL_W, 16, signed sample width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- wrt_smpl  in  1  one-cycle strobe; new sample pair present on lft_smpl/rght_smpl.
- lft_smpl  in  SMPL_W  signed left sample.
- rght_smpl  in  SMPL_W  signed right sample.
- seq  out  1  high while lft_out/rght_out carry a valid burst sample.
- lft_out  out  SMPL_W  burst left sample (drives FIR lft_in).
- rght_out  out  SMPL_W  burst right sample (drives FIR rght_in).

Behaviour:
- Reset: seq=0, lft_out=0, rght_out=0, new_ptr=0, old_ptr=0, rd_ptr=0, cnt=0, state=IDLE. Memory contents are not reset.
- Storage: DEPTH x (2*SMPL_W) RAM.
  - Synchronous write at new_ptr.
  - Synchronous read with 1-cycle latency.
  - Pointers wrap DEPTH-1 -> 0.
- Write accepted only in IDLE:
  - mem[new_ptr] <= {lft_smpl, rght_smpl}; new_ptr++ with wrap.
  - If cnt==READ_LEN before the write: old_ptr++ with wrap, then start a burst.
  - Else: cnt++. If cnt becomes READ_LEN, start a burst at the unchanged old_ptr (0 after reset).
  - If cnt<READ_LEN after the write: no burst.
- States IDLE -> READ -> IDLE:
  - IDLE->READ on a burst start: rd_ptr <= (updated) old_ptr; rd_cnt <= 0.
  - READ: issue RAM read at rd_ptr each cycle; rd_ptr++ with wrap; rd_cnt++. After READ_LEN reads, go to IDLE.
- Latency:
  - wrt_smpl sampled at edge E0.
  - First RAM address issued in the cycle after E0.
  - First sample registered onto lft_out/rght_out with seq=1 in the following cycle, i.e. seq rises 2 cycles after the wrt_smpl cycle.
  - seq stays high exactly READ_LEN consecutive cycles; output i = i-th oldest of the last READ_LEN pairs.
  - seq falls the cycle after the last sample.
  - lft_out/rght_out hold their last value when seq=0.
- Burst content: always the READ_LEN most recent pairs, including the one just written, oldest first. Contiguous across the DEPTH-1 -> 0 wrap.
- wrt_smpl while in READ, or while the output pipeline is still draining: sample dropped; no pointer/cnt change.
- wrt_smpl held high for several cycles: each cycle in IDLE is a separate write. Upstream guarantees one-cycle strobes.
- Reset mid-burst: seq drops asynchronously. All pointers and cnt clear; the queue refills from empty.
- Elaboration: fatal error if DEPTH <= READ_LEN or READ_LEN < 2.

Optional Feature:
- Macro: SAMPLE_QUEUE_OVERRUN_EN.
- Defined:
  - Adds output port `overrun` (1 bit), reset 0.
  - Set sticky on any dropped wrt_smpl; cleared only by rst_n.
- Undefined:
  - No port.
  - Drops are silent; no extra logic.

Decomposition:
- Package eq_pkg:
  - SMPL_W default.
  - Queue state typedef `enum {IDLE, READ}`.
  - Default DEPTH/READ_LEN constants for the low/high band queues.
- Sub-module dp_ram_queue:
  - Simple dual-port RAM, DEPTH x 2*SMPL_W.
  - One write port, one synchronous read port.
  - No reset.
  - Instantiated once by sample_queue.

Test Plan:
- Fill: write values 1..1020 (left=k, right=-k) with 100-cycle spacing -> seq never asserts. Write 1021 -> seq high exactly 1021 cycles starting 2 cycles after the strobe; lft_out sequence 1..1021, rght_out -1..-1021.
- Slide: write 1022 after the burst -> burst 2..1022. Write 1023 -> burst 3..1023.
- Wrap: write 1..2000 continuously (idle between bursts) -> last burst is 980..2000 with no gap or repeat across the physical index 1535 -> 0 boundary.
- Drop: pulse wrt_smpl with 5555 mid-burst -> burst unchanged, next burst omits 5555. With SAMPLE_QUEUE_OVERRUN_EN, overrun=1 and stays 1.
- Reset mid-burst: assert rst_n=0 at burst cycle 500 -> seq, lft_out, rght_out go 0 immediately. After release, 1020 writes give no seq; the 1021st gives a burst of the new data only.
- Reset values: release reset with no writes for 50 cycles -> seq=0, lft_out=0, rght_out=0 throughout.
